// File: rtl/sq_calc_pkg.sv
// Shared definitions for the stack/queue calculator sequencer: FSM states and
// storage-mode encodings.
package sq_calc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP_A  = 3'd1,
        POP_B  = 3'd2,
        EXEC   = 3'd3,
        PUSH_Y = 3'd4
    } state_t;

    localparam logic MODE_STACK = 1'b0;
    localparam logic MODE_QUEUE = 1'b1;

endpackage

// File: rtl/sq_store.sv
// Circular operand buffer. Pushes always land at the tail; entries leave either
// from the head (oldest) or from just behind the tail (newest).
module sq_store #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop_front,
    input  logic                       pop_back,
    input  logic                       flush,
    input  logic                       lifo,
    output logic [DATA_W-1:0]          top,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head_reg;
    logic [PW-1:0]     tail_reg;
    logic [CW-1:0]     count_reg;
    logic [PW-1:0]     tail_m1;

    assign tail_m1 = tail_reg - PTR_ONE;
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_MAX);
    assign count   = count_reg;
    assign top     = empty ? '0 : (lifo ? mem[tail_m1] : mem[head_reg]);

    // Storage has no reset: validity is tracked by count_reg alone.
    always_ff @(posedge clk) begin
        if (push && !full && !flush) begin
            mem[tail_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (push && !full) begin
            tail_reg  <= tail_reg + PTR_ONE;
            count_reg <= count_reg + CNT_ONE;
        end else if (pop_front && !empty) begin
            head_reg  <= head_reg + PTR_ONE;
            count_reg <= count_reg - CNT_ONE;
        end else if (pop_back && !empty) begin
            tail_reg  <= tail_m1;
            count_reg <= count_reg - CNT_ONE;
        end
    end

endmodule

// File: rtl/stack_queue_sequencer.sv
// Operand sequencer for an external ALU: pushes switch literals, pops one or two
// operands, strobes the ALU, and pushes the result back into the same buffer.
module stack_queue_sequencer
    import sq_calc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int SW_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [SW_W-1:0]        sw,
    input  logic                   push_req,
    input  logic                   op_req,
    input  logic                   op_unary,
    input  logic [DATA_W-1:0]      alu_y,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic                   alu_go,
    output logic [DATA_W-1:0]      top,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   busy,
    output logic                   err_underflow,
    output logic                   err_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_TWO = 2;

    state_t            state_reg, state_next;
    logic              mode_reg;
    logic              push_prev_reg, op_prev_reg;
    logic              unary_reg;
    logic [DATA_W-1:0] alu_a_reg, alu_b_reg, y_reg;
    logic              err_uf_reg, err_of_reg;

    logic              push_edge, op_edge, mode_change;
    logic              st_push, st_pop, st_flush;
    logic [DATA_W-1:0] st_push_data;
    logic              load_a, load_b, clear_b, cap_y, op_start;
    logic              set_of, set_uf, clr_err;

    assign push_edge   = push_req & ~push_prev_reg;
    assign op_edge     = op_req & ~op_prev_reg;
    assign mode_change = (state_reg == IDLE) && (mode != mode_reg);

    always_comb begin
        state_next   = state_reg;
        st_push      = 1'b0;
        st_push_data = '0;
        st_pop       = 1'b0;
        st_flush     = 1'b0;
        load_a       = 1'b0;
        load_b       = 1'b0;
        clear_b      = 1'b0;
        cap_y        = 1'b0;
        op_start     = 1'b0;
        set_of       = 1'b0;
        set_uf       = 1'b0;
        clr_err      = 1'b0;
        case (state_reg)
            IDLE: begin
                // A pending mode switch takes the whole cycle; simultaneous
                // push/op edges cancel each other without any side effect.
                if (mode_change) begin
                    st_flush = 1'b1;
                end else if (push_edge && op_edge) begin
                    st_flush = 1'b0;
                end else if (push_edge) begin
                    if (full) begin
                        set_of = 1'b1;
                    end else begin
                        st_push      = 1'b1;
                        st_push_data = DATA_W'(sw);
                        clr_err      = 1'b1;
                    end
                end else if (op_edge) begin
                    if (op_unary ? empty : (count < CNT_TWO)) begin
                        set_uf = 1'b1;
                    end else begin
                        clr_err    = 1'b1;
                        op_start   = 1'b1;
                        state_next = POP_A;
                    end
                end
            end
            POP_A: begin
                load_a = 1'b1;
                st_pop = 1'b1;
                if (unary_reg) begin
                    clear_b    = 1'b1;
                    state_next = EXEC;
                end else begin
                    state_next = POP_B;
                end
            end
            POP_B: begin
                load_b     = 1'b1;
                st_pop     = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                cap_y      = 1'b1;
                state_next = PUSH_Y;
            end
            PUSH_Y: begin
                st_push      = 1'b1;
                st_push_data = y_reg;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            mode_reg      <= MODE_STACK;
            push_prev_reg <= 1'b0;
            op_prev_reg   <= 1'b0;
            unary_reg     <= 1'b0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            y_reg         <= '0;
            err_uf_reg    <= 1'b0;
            err_of_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            push_prev_reg <= push_req;
            op_prev_reg   <= op_req;
            if (mode_change) mode_reg <= mode;
            if (op_start) unary_reg <= op_unary;
            if (load_a) alu_a_reg <= top;
            if (load_b) alu_b_reg <= top;
            else if (clear_b) alu_b_reg <= '0;
            if (cap_y) y_reg <= alu_y;
            if (clr_err) begin
                err_uf_reg <= 1'b0;
                err_of_reg <= 1'b0;
            end else begin
                if (set_uf) err_uf_reg <= 1'b1;
                if (set_of) err_of_reg <= 1'b1;
            end
        end
    end

    sq_store #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .push      (st_push),
        .push_data (st_push_data),
        .pop_front (st_pop && (mode_reg == MODE_QUEUE)),
        .pop_back  (st_pop && (mode_reg == MODE_STACK)),
        .flush     (st_flush),
        .lifo      (mode_reg == MODE_STACK),
        .top       (top),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    assign alu_a         = alu_a_reg;
    assign alu_b         = alu_b_reg;
    assign alu_go        = (state_reg == EXEC);
    assign busy          = (state_reg != IDLE);
    assign err_underflow = err_uf_reg;
    assign err_overflow  = err_of_reg;

endmodule

// File: tb/tb_stack_queue_sequencer.sv
// Directed bench for stack_queue_sequencer (DEPTH=4) with an add/multiply
// reference ALU built from the DUT's operand outputs.
module tb_stack_queue_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] sw = '0;
    logic        push_req = 1'b0;
    logic        op_req = 1'b0;
    logic        op_unary = 1'b0;
    logic [31:0] alu_y;
    logic [31:0] alu_a, alu_b, top;
    logic        alu_go;
    logic [2:0]  count;
    logic        empty, full, busy, err_underflow, err_overflow;
    logic        alu_mul = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int bc, gc;

    always #5 clk = ~clk;

    assign alu_y = alu_mul ? (alu_a * alu_b) : (alu_a + alu_b);

    stack_queue_sequencer #(.DATA_W(32), .DEPTH(4), .SW_W(16)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sw(sw), .push_req(push_req),
        .op_req(op_req), .op_unary(op_unary), .alu_y(alu_y), .alu_a(alu_a),
        .alu_b(alu_b), .alu_go(alu_go), .top(top), .count(count), .empty(empty),
        .full(full), .busy(busy), .err_underflow(err_underflow),
        .err_overflow(err_overflow)
    );

    task automatic do_push(input logic [15:0] v);
        @(negedge clk);
        sw = v;
        push_req = 1'b1;
        @(negedge clk);
        push_req = 1'b0;
        $display("push %0d -> count=%0d top=%0d", v, count, top);
    endtask

    // Issues one op edge and counts busy / alu_go cycles until IDLE (bounded).
    task automatic run_op(input logic u);
        bc = 0;
        gc = 0;
        @(negedge clk);
        op_req = 1'b1;
        op_unary = u;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            op_req = 1'b0;
            if (busy) bc++;
            if (alu_go) gc++;
            if (!busy) break;
        end
        $display("op unary=%0b -> a=%0d b=%0d busy=%0d go=%0d count=%0d top=%0d",
                 u, alu_a, alu_b, bc, gc, count, top);
    endtask

    task automatic set_mode(input logic m);
        @(negedge clk);
        mode = m;
        @(negedge clk);
        $display("mode %0b -> count=%0d", m, count);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++; if (count !== 3'd0) $display("FAIL rst_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL rst_empty: got %0b expected 1", empty); else n_pass++;
        n_checks++; if ({full, busy, alu_go, err_underflow, err_overflow} !== 5'b0)
            $display("FAIL rst_flags: got %b expected 00000", {full, busy, alu_go, err_underflow, err_overflow}); else n_pass++;
        n_checks++; if ({alu_a, alu_b, top} !== 96'd0)
            $display("FAIL rst_data: got a=%0d b=%0d top=%0d expected 0", alu_a, alu_b, top); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_stack;
        do_push(16'd5);
        do_push(16'd3);
        n_checks++; if (top !== 32'd3) $display("FAIL stk_top_pre: got %0d expected 3", top); else n_pass++;
        run_op(1'b0);
        n_checks++; if (alu_a !== 32'd3) $display("FAIL stk_a: got %0d expected 3", alu_a); else n_pass++;
        n_checks++; if (alu_b !== 32'd5) $display("FAIL stk_b: got %0d expected 5", alu_b); else n_pass++;
        n_checks++; if (gc !== 1) $display("FAIL stk_go: got %0d expected 1", gc); else n_pass++;
        n_checks++; if (bc !== 4) $display("FAIL stk_busy: got %0d expected 4", bc); else n_pass++;
        n_checks++; if (top !== 32'd8) $display("FAIL stk_top: got %0d expected 8", top); else n_pass++;
        n_checks++; if (count !== 3'd1) $display("FAIL stk_count: got %0d expected 1", count); else n_pass++;
    endtask

    task automatic test_queue;
        set_mode(1'b1);
        n_checks++; if (count !== 3'd0) $display("FAIL q_flush: got %0d expected 0", count); else n_pass++;
        alu_mul = 1'b1;
        do_push(16'd7);
        do_push(16'd2);
        do_push(16'd9);
        run_op(1'b0);
        n_checks++; if (alu_a !== 32'd7) $display("FAIL q_a: got %0d expected 7", alu_a); else n_pass++;
        n_checks++; if (alu_b !== 32'd2) $display("FAIL q_b: got %0d expected 2", alu_b); else n_pass++;
        n_checks++; if (count !== 3'd2) $display("FAIL q_count: got %0d expected 2", count); else n_pass++;
        n_checks++; if (top !== 32'd9) $display("FAIL q_top: got %0d expected 9", top); else n_pass++;
        run_op(1'b1);
        n_checks++; if (alu_a !== 32'd9) $display("FAIL q_pop1: got %0d expected 9", alu_a); else n_pass++;
        run_op(1'b1);
        n_checks++; if (alu_a !== 32'd14) $display("FAIL q_pop2: got %0d expected 14", alu_a); else n_pass++;
        alu_mul = 1'b0;
    endtask

    task automatic test_overflow;
        set_mode(1'b0);
        for (int v = 1; v <= 5; v++) do_push(16'(v));
        n_checks++; if (count !== 3'd4) $display("FAIL of_count: got %0d expected 4", count); else n_pass++;
        n_checks++; if (full !== 1'b1) $display("FAIL of_full: got %0b expected 1", full); else n_pass++;
        n_checks++; if (err_overflow !== 1'b1) $display("FAIL of_err: got %0b expected 1", err_overflow); else n_pass++;
        n_checks++; if (top !== 32'd4) $display("FAIL of_top: got %0d expected 4", top); else n_pass++;
        run_op(1'b0);
        n_checks++; if (err_overflow !== 1'b0) $display("FAIL of_clear: got %0b expected 0", err_overflow); else n_pass++;
        n_checks++; if (top !== 32'd7) $display("FAIL of_sum: got %0d expected 7", top); else n_pass++;
    endtask

    task automatic test_underflow;
        set_mode(1'b1);
        set_mode(1'b0);
        do_push(16'd6);
        run_op(1'b0);
        n_checks++; if (err_underflow !== 1'b1) $display("FAIL uf_err: got %0b expected 1", err_underflow); else n_pass++;
        n_checks++; if (bc !== 0) $display("FAIL uf_busy: got %0d expected 0", bc); else n_pass++;
        n_checks++; if (count !== 3'd1 || top !== 32'd6)
            $display("FAIL uf_store: got count=%0d top=%0d expected 1/6", count, top); else n_pass++;
        run_op(1'b1);
        n_checks++; if (alu_a !== 32'd6) $display("FAIL un_a: got %0d expected 6", alu_a); else n_pass++;
        n_checks++; if (alu_b !== 32'd0) $display("FAIL un_b: got %0d expected 0", alu_b); else n_pass++;
        n_checks++; if (bc !== 3) $display("FAIL un_busy: got %0d expected 3", bc); else n_pass++;
        n_checks++; if (err_underflow !== 1'b0) $display("FAIL un_clear: got %0b expected 0", err_underflow); else n_pass++;
    endtask

    task automatic test_reset_midop;
        do_push(16'd1);
        do_push(16'd2);
        @(negedge clk);
        op_req = 1'b1;
        op_unary = 1'b0;
        @(negedge clk);
        op_req = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy: got %0b expected 1", busy); else n_pass++;
        #2 rst = 1'b0;
        sw = 16'd11;
        push_req = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || count !== 3'd0 || empty !== 1'b1)
            $display("FAIL mid_rst: got busy=%0b count=%0d empty=%0b expected 0/0/1", busy, count, empty); else n_pass++;
        n_checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0)
            $display("FAIL mid_ops: got a=%0d b=%0d expected 0/0", alu_a, alu_b); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("reset during POP_B, held push after release -> count=%0d", count);
        n_checks++; if (count !== 3'd1 || top !== 32'd11)
            $display("FAIL mid_held: got count=%0d top=%0d expected 1/11", count, top); else n_pass++;
        push_req = 1'b0;
    endtask

    task automatic test_handshake;
        @(negedge clk);
        sw = 16'd20;
        push_req = 1'b1;
        repeat (10) @(negedge clk);
        push_req = 1'b0;
        @(negedge clk);
        $display("held push x10 -> count=%0d", count);
        n_checks++; if (count !== 3'd2 || top !== 32'd20)
            $display("FAIL hold_once: got count=%0d top=%0d expected 2/20", count, top); else n_pass++;
        @(negedge clk);
        sw = 16'd33;
        push_req = 1'b1;
        op_req = 1'b1;
        @(negedge clk);
        push_req = 1'b0;
        op_req = 1'b0;
        @(negedge clk);
        $display("push+op same cycle -> count=%0d busy=%0b", count, busy);
        n_checks++; if (count !== 3'd2 || top !== 32'd20 || busy !== 1'b0)
            $display("FAIL both_store: got count=%0d top=%0d busy=%0b expected 2/20/0", count, top, busy); else n_pass++;
        n_checks++; if (err_underflow !== 1'b0 || err_overflow !== 1'b0)
            $display("FAIL both_err: got %0b%0b expected 00", err_underflow, err_overflow); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_stack;
        test_queue;
        test_overflow;
        test_underflow;
        test_reset_midop;
        test_handshake;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
